// File: rtl/pwm_device_v2.sv
// pwm_device_v2: one shared counter driving OUTPUTS compare channels, with edge/centre
// alignment, clock prescaler, per-output polarity and a period-boundary interrupt.
// Optional build macro PWM_SHADOW_EN: TOP/COMPARE writes land in shadow copies that load
// into the active copies at the period boundary (or every clk while disabled).
module pwm_device_v2 #(
    parameter logic [7:0]  ID          = 8'h01,
    parameter int unsigned OUTPUTS     = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned CLOCK_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               peripheralEnable,
    input  logic               peripheralBus_we,
    input  logic               peripheralBus_oe,
    output logic               peripheralBus_busy,
    input  logic [15:0]        peripheralBus_address,
    input  logic [3:0]         peripheralBus_byteSelect,
    input  logic [31:0]        peripheralBus_dataWrite,
    output logic [31:0]        peripheralBus_dataRead,
    output logic               requestOutput,
    output logic [OUTPUTS-1:0] pwm_en,
    output logic [OUTPUTS-1:0] pwm_out,
    output logic               pwm_irq
);

    localparam logic [5:0] CMP_BASE_WORD = 6'd4;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        for (int i = 0; i < 4; i++) begin
            merge_bytes[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
    endfunction

    logic                          en_q, en_d, center_q, center_d;
    logic                          irq_en_q, irq_en_d, irq_pending_q, irq_pending_d;
    logic [OUTPUTS-1:0]            out_en_q, out_en_d, invert_q, invert_d;
    logic [CLOCK_WIDTH-1:0]        prescale_q, prescale_d, pscnt_q, pscnt_d;
    logic [WIDTH-1:0]              top_q, top_d, counter_q, counter_d;
    logic [OUTPUTS-1:0][WIDTH-1:0] cmp_q, cmp_d;
    logic                          dir_down_q, dir_down_d;
    logic [OUTPUTS-1:0]            pwm_out_q, pwm_out_d;

    logic [WIDTH-1:0]              top_act;
    logic [OUTPUTS-1:0][WIDTH-1:0] cmp_act;
    logic                          tick, boundary;

    logic [5:0]  off_word, cmp_idx;
    logic        word_ok, id_match, wr_en;
    logic        sel_cfg, sel_pre, sel_top, sel_cnt, sel_cmp, mapped;
    logic [31:0] cfg_rd, cfg_wr, rd_data;
    logic        unused_cfg_bits;

    // Address decode for this device's register window
    assign off_word = peripheralBus_address[7:2];
    assign cmp_idx  = off_word - CMP_BASE_WORD;
    assign word_ok  = (peripheralBus_address[1:0] == 2'b00);
    assign id_match = (peripheralBus_address[15:8] == ID);
    assign sel_cfg  = word_ok && (off_word == 6'd0);
    assign sel_pre  = word_ok && (off_word == 6'd1);
    assign sel_top  = word_ok && (off_word == 6'd2);
    assign sel_cnt  = word_ok && (off_word == 6'd3);
    assign sel_cmp  = word_ok && (off_word >= CMP_BASE_WORD) && (32'(cmp_idx) < OUTPUTS);
    assign mapped   = sel_cfg || sel_pre || sel_top || sel_cnt || sel_cmp;
    assign wr_en    = peripheralEnable && peripheralBus_we && id_match;

    // Register file writes with byte lanes; IRQ_PENDING is set by hardware, cleared by W1C
    always_comb begin
        cfg_rd                  = '0;
        cfg_rd[0]               = en_q;
        cfg_rd[1]               = center_q;
        cfg_rd[2]               = irq_en_q;
        cfg_rd[3]               = irq_pending_q;
        cfg_rd[8 +: OUTPUTS]    = out_en_q;
        cfg_rd[16 +: OUTPUTS]   = invert_q;
        cfg_wr = merge_bytes(cfg_rd, peripheralBus_dataWrite, peripheralBus_byteSelect);

        en_d          = en_q;
        center_d      = center_q;
        irq_en_d      = irq_en_q;
        irq_pending_d = irq_pending_q;
        out_en_d      = out_en_q;
        invert_d      = invert_q;
        prescale_d    = prescale_q;
        top_d         = top_q;
        cmp_d         = cmp_q;

        if (wr_en && sel_cfg) begin
            en_d     = cfg_wr[0];
            center_d = cfg_wr[1];
            irq_en_d = cfg_wr[2];
            out_en_d = cfg_wr[8 +: OUTPUTS];
            invert_d = cfg_wr[16 +: OUTPUTS];
            if (peripheralBus_byteSelect[0] && peripheralBus_dataWrite[3]) begin
                irq_pending_d = 1'b0;
            end
        end
        if (wr_en && sel_pre) begin
            prescale_d = CLOCK_WIDTH'(merge_bytes(32'(prescale_q), peripheralBus_dataWrite,
                                                  peripheralBus_byteSelect));
        end
        if (wr_en && sel_top) begin
            top_d = WIDTH'(merge_bytes(32'(top_q), peripheralBus_dataWrite,
                                       peripheralBus_byteSelect));
        end
        for (int unsigned k = 0; k < OUTPUTS; k++) begin
            if (wr_en && sel_cmp && (cmp_idx == 6'(k))) begin
                cmp_d[k] = WIDTH'(merge_bytes(32'(cmp_q[k]), peripheralBus_dataWrite,
                                              peripheralBus_byteSelect));
            end
        end
        // A set at the boundary wins over a simultaneous clear
        if (boundary && irq_en_q) begin
            irq_pending_d = 1'b1;
        end
    end

    assign unused_cfg_bits = ^cfg_wr;

`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0]              top_act_q, top_act_d;
    logic [OUTPUTS-1:0][WIDTH-1:0] cmp_act_q, cmp_act_d;

    // Active copies follow the shadows at each period boundary, or continuously while idle
    always_comb begin
        top_act_d = top_act_q;
        cmp_act_d = cmp_act_q;
        if (!en_q || boundary) begin
            top_act_d = top_q;
            cmp_act_d = cmp_q;
        end
    end

    // Active copy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_act_q <= '0;
            cmp_act_q <= '0;
        end else begin
            top_act_q <= top_act_d;
            cmp_act_q <= cmp_act_d;
        end
    end

    assign top_act = top_act_q;
    assign cmp_act = cmp_act_q;
`else
    assign top_act = top_q;
    assign cmp_act = cmp_q;
`endif

    // Prescaler and shared counter; disabling or switching mode restarts from 0 counting up
    always_comb begin
        pscnt_d    = pscnt_q;
        counter_d  = counter_q;
        dir_down_d = dir_down_q;
        tick       = 1'b0;
        boundary   = 1'b0;
        if (!en_d || (en_q && (center_d != center_q))) begin
            pscnt_d    = '0;
            counter_d  = '0;
            dir_down_d = 1'b0;
        end else if (en_q) begin
            if (pscnt_q >= prescale_q) begin
                tick    = 1'b1;
                pscnt_d = '0;
            end else begin
                pscnt_d = pscnt_q + CLOCK_WIDTH'(1);
            end
            if (tick) begin
                if (!center_q) begin
                    if (counter_q >= top_act) begin
                        counter_d = '0;
                        boundary  = 1'b1;
                    end else begin
                        counter_d = counter_q + WIDTH'(1);
                    end
                end else if (top_act == '0) begin
                    counter_d  = '0;
                    dir_down_d = 1'b0;
                    boundary   = 1'b1;
                end else if (dir_down_q || (counter_q >= top_act)) begin
                    // Reaching 0 on the way down closes the period and turns back up
                    if (counter_q <= WIDTH'(1)) begin
                        counter_d  = '0;
                        dir_down_d = 1'b0;
                        boundary   = 1'b1;
                    end else begin
                        counter_d  = counter_q - WIDTH'(1);
                        dir_down_d = 1'b1;
                    end
                end else begin
                    counter_d = counter_q + WIDTH'(1);
                end
            end
        end
    end

    // Compare outputs with polarity; idle level is the INVERT bit
    always_comb begin
        pwm_out_d = '0;
        for (int unsigned k = 0; k < OUTPUTS; k++) begin
            pwm_out_d[k] = en_q ? ((counter_q < cmp_act[k]) ^ invert_q[k]) : invert_q[k];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q          <= 1'b0;
            center_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            out_en_q      <= '0;
            invert_q      <= '0;
            prescale_q    <= '0;
            top_q         <= '0;
            cmp_q         <= '0;
            pscnt_q       <= '0;
            counter_q     <= '0;
            dir_down_q    <= 1'b0;
            pwm_out_q     <= '0;
        end else begin
            en_q          <= en_d;
            center_q      <= center_d;
            irq_en_q      <= irq_en_d;
            irq_pending_q <= irq_pending_d;
            out_en_q      <= out_en_d;
            invert_q      <= invert_d;
            prescale_q    <= prescale_d;
            top_q         <= top_d;
            cmp_q         <= cmp_d;
            pscnt_q       <= pscnt_d;
            counter_q     <= counter_d;
            dir_down_q    <= dir_down_d;
            pwm_out_q     <= pwm_out_d;
        end
    end

    // Read mux; reads of TOP/COMPARE return the programmed (shadow) values
    always_comb begin
        rd_data = '0;
        if (sel_cfg) begin
            rd_data = cfg_rd;
        end else if (sel_pre) begin
            rd_data = 32'(prescale_q);
        end else if (sel_top) begin
            rd_data = 32'(top_q);
        end else if (sel_cnt) begin
            rd_data = 32'(counter_q);
        end else begin
            for (int unsigned k = 0; k < OUTPUTS; k++) begin
                if (sel_cmp && (cmp_idx == 6'(k))) begin
                    rd_data = 32'(cmp_q[k]);
                end
            end
        end
    end

    assign requestOutput          = peripheralEnable && peripheralBus_oe && id_match && mapped;
    assign peripheralBus_dataRead = requestOutput ? rd_data : '1;
    assign peripheralBus_busy     = 1'b0;
    assign pwm_en                 = out_en_q & {OUTPUTS{en_q}};
    assign pwm_out                = pwm_out_q;
    assign pwm_irq                = irq_pending_q && irq_en_q;

endmodule
